// File: rtl/spm_pkg.sv
// Shared definitions for the signed serial-parallel multiplier.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package spm_pkg;

  localparam int N_DEF  = 8;
  localparam int PW_DEF = 2 * N_DEF;
  localparam int CW_DEF = $clog2(PW_DEF) + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Bit counter width for an n-bit operand: enough to count 2n product bits.
  function automatic int cnt_width(input int n);
    return $clog2(2 * n) + 1;
  endfunction

endpackage

// File: rtl/spm_csa_cell.sv
// One carry-save column: full adder of (x_j & y_i), the neighbour sum and the own carry.
// Latency: sum/carry registered each enabled cycle; LSB cell exposes its sum combinationally.
// Backpressure: none; advances whenever en is high, cleared synchronously by clr.
module spm_csa_cell #(
  parameter bit LSB = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  input  logic x_bit,
  input  logic y_bit,
  input  logic sum_in,
  output logic sum_out
);

  logic sum_q;
  logic carry_q;
  logic pp;
  logic sum_d;
  logic carry_d;

  assign pp      = x_bit & y_bit;
  assign sum_d   = pp ^ sum_in ^ carry_q;
  assign carry_d = (pp & sum_in) | (pp & carry_q) | (sum_in & carry_q);

  // The LSB column's sum is the product bit of this cycle; other columns hand
  // their registered sum to the column on their right.
  assign sum_out = LSB ? sum_d : sum_q;

  // Sum and carry state, cleared on start.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_q   <= 1'b0;
      carry_q <= 1'b0;
    end else if (clr) begin
      sum_q   <= 1'b0;
      carry_q <= 1'b0;
    end else if (en) begin
      sum_q   <= sum_d;
      carry_q <= carry_d;
    end
  end

endmodule

// File: rtl/signed_spm.sv
// Signed NxN serial-parallel multiplier; Y fed LSB first, one product bit per clock.
// Latency: done and final P_reg on edge 2N after the start edge (16 cycles for N=8).
// Backpressure: Go ignored while running; result held with done until the next start.
// Optional: SPM_BUSY_EN adds a registered busy output, high exactly while running.
module signed_spm
  import spm_pkg::*;
#(
  parameter int N = N_DEF
) (
  input  logic           clk,
  input  logic           R,
  input  logic [N-1:0]   X,
  input  logic [N-1:0]   Y,
  input  logic           Go,
  output logic           done,
  output logic [2*N-1:0] P_reg
`ifdef SPM_BUSY_EN
  ,
  output logic           busy
`endif
);

  localparam int PW  = 2 * N;
  localparam int CW  = cnt_width(N);
  localparam int YIW = $clog2(N);
  localparam logic [CW-1:0] N_C    = CW'(N);
  localparam logic [CW-1:0] LAST_C = CW'(PW - 1);

  state_t        state;
  state_t        state_n;
  logic [N-1:0]  x_r;
  logic [N-1:0]  y_r;
  logic [CW-1:0] cnt;
  logic          y_bit;
  logic          start;
  logic          running;
  logic          last;
  logic [N-1:0]  sum_w;
  logic          busy_q;

  assign running = (state == RUN);
  assign start   = Go && !running;
  assign last    = running && (cnt == LAST_C);

  // Serial multiplier bit: Y bits first, then its sign bit repeated.
  always_comb begin
    y_bit = y_r[N-1];
    if (cnt < N_C) y_bit = y_r[cnt[YIW-1:0]];
  end

  // Carry-save columns. The MSB column takes its own registered sum as the
  // neighbour sum, which makes it stand in for every sign-extended column above it.
  for (genvar j = 0; j < N; j++) begin : g_cell
    spm_csa_cell #(
      .LSB (j == 0)
    ) u_cell (
      .clk     (clk),
      .rst_n   (R),
      .clr     (start),
      .en      (running),
      .x_bit   (x_r[j]),
      .y_bit   (y_bit),
      .sum_in  ((j == N - 1) ? sum_w[N-1] : sum_w[(j + 1) % N]),
      .sum_out (sum_w[j])
    );
  end

  // FSM state register.
  always_ff @(posedge clk or negedge R) begin
    if (!R) state <= IDLE;
    else    state <= state_n;
  end

  // Next-state logic: start from IDLE or DONE, finish after 2N product bits.
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (Go)   state_n = RUN;
      RUN:     if (last) state_n = DONE;
      DONE:    if (Go)   state_n = RUN;
      default:           state_n = IDLE;
    endcase
  end

  // Operand latch, bit counter, product shifter and status flags.
  always_ff @(posedge clk or negedge R) begin
    if (!R) begin
      x_r    <= '0;
      y_r    <= '0;
      cnt    <= '0;
      P_reg  <= '0;
      done   <= 1'b0;
      busy_q <= 1'b0;
    end else if (start) begin
      x_r    <= X;
      y_r    <= Y;
      cnt    <= '0;
      P_reg  <= '0;
      done   <= 1'b0;
      busy_q <= 1'b1;
    end else if (running) begin
      P_reg <= {sum_w[0], P_reg[PW-1:1]};
      cnt   <= cnt + 1'b1;
      if (last) begin
        done   <= 1'b1;
        busy_q <= 1'b0;
      end
    end
  end

`ifdef SPM_BUSY_EN
  assign busy = busy_q;
`else
  logic unused_busy;
  assign unused_busy = busy_q;
`endif

endmodule

// File: tb/tb_signed_spm.sv
module tb_signed_spm;

  localparam int N = 8;

  logic         clk = 1'b0;
  logic         R   = 1'b0;
  logic         Go  = 1'b0;
  logic [N-1:0] X   = '0;
  logic [N-1:0] Y   = '0;
  logic         done;
  logic [2*N-1:0] P_reg;
`ifdef SPM_BUSY_EN
  logic         busy;
`endif

  always #5 clk = ~clk;

  signed_spm #(.N(N)) dut (
    .clk   (clk),
    .R     (R),
    .X     (X),
    .Y     (Y),
    .Go    (Go),
    .done  (done),
    .P_reg (P_reg)
`ifdef SPM_BUSY_EN
    ,
    .busy  (busy)
`endif
  );

  typedef struct {
    logic [15:0] p;
    time         t0;
  } exp_t;

  exp_t        sb[$];
  int          total = 0;
  int          bad = 0;
  logic [15:0] last_exp = '0;
  bit          have_last = 1'b0;
  bit          done_q = 1'b0;
  int          busy_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: plain signed product, truncated to 16 bits.
  function automatic logic [15:0] ref_mul(input logic [7:0] a, input logic [7:0] b);
    int pa;
    int pb;
    int pr;
    pa = int'($signed(a));
    pb = int'($signed(b));
    pr = pa * pb;
    return pr[15:0];
  endfunction

  task automatic start(input logic [7:0] a, input logic [7:0] b);
    exp_t e;
    @(negedge clk);
    X  = a;
    Y  = b;
    Go = 1'b1;
    @(posedge clk);
    e.p  = ref_mul(a, b);
    e.t0 = $time;
    sb.push_back(e);
    @(negedge clk);
    Go = 1'b0;
    chk("done_low_after_start", {31'd0, done}, 32'd0);
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (!done && n < 40) begin
      @(negedge clk);
      n++;
    end
    #1;
    chk("done_timeout", {31'd0, done}, 32'd1);
  endtask

  // Monitor: on each rising done, pop the oldest expected product and check it,
  // its latency and (optionally) the busy window; check the result holds while done.
  always @(negedge clk) begin
    exp_t e;
    if (!R) begin
      done_q    = 1'b0;
      busy_cnt  = 0;
      have_last = 1'b0;
    end else begin
`ifdef SPM_BUSY_EN
      if (busy) busy_cnt++;
`endif
      if (done && !done_q) begin
        if (sb.size() == 0) begin
          chk("spurious_done", {31'd0, done}, 32'd0);
        end else begin
          e = sb.pop_front();
          chk("product", {16'd0, P_reg}, {16'd0, e.p});
          chk("latency", 32'(($time - 5 - e.t0) / 10), 32'd16);
          last_exp  = e.p;
          have_last = 1'b1;
`ifdef SPM_BUSY_EN
          chk("busy_cycles", busy_cnt, 32'd16);
          chk("busy_low_at_done", {31'd0, busy}, 32'd0);
`endif
          busy_cnt = 0;
        end
      end else if (done && have_last) begin
        chk("result_hold", {16'd0, P_reg}, {16'd0, last_exp});
      end
      done_q = done;
    end
  end

  initial begin
    logic [7:0] da[5];
    logic [7:0] db[5];
    logic [15:0] dp[5];

    da = '{8'h80, 8'hF3, 8'h7F, 8'h80, 8'h00};
    db = '{8'h80, 8'h03, 8'h7F, 8'h7F, 8'hFF};
    dp = '{16'h4000, 16'hFFD9, 16'h3F01, 16'hC080, 16'h0000};

    // Reset and idle.
    R = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset_p", {16'd0, P_reg}, 32'd0);
    chk("reset_done", {31'd0, done}, 32'd0);
`ifdef SPM_BUSY_EN
    chk("reset_busy", {31'd0, busy}, 32'd0);
`endif
    R = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("idle_done", {31'd0, done}, 32'd0);
    end

    // Directed pairs with independently known products.
    for (int i = 0; i < 5; i++) begin
      start(da[i], db[i]);
      wait_done();
      chk("directed_const", {16'd0, P_reg}, {16'd0, dp[i]});
    end

    // Go re-pulsed mid-run and operands changed: original result must complete.
    start(8'd100, 8'hC5);
    repeat (4) @(negedge clk);
    Go = 1'b1;
    X  = 8'h11;
    Y  = 8'h22;
    @(negedge clk);
    Go = 1'b0;
    X  = 8'h7E;
    Y  = 8'h81;
    wait_done();

    // Asynchronous reset mid-run, then a fresh product.
    start(8'h22, 8'h33);
    repeat (8) @(posedge clk);
    #2 R = 1'b0;
    #1;
    chk("midrun_reset_p", {16'd0, P_reg}, 32'd0);
    chk("midrun_reset_done", {31'd0, done}, 32'd0);
    sb.delete();
    @(negedge clk);
    @(negedge clk);
    R = 1'b1;
    start(8'd5, 8'hF9);
    wait_done();
    chk("after_reset_const", {16'd0, P_reg}, 32'h0000FFDD);

    // Randomized back-to-back runs, including the extreme operand values.
    for (int i = 0; i < 30; i++) begin
      logic [7:0] a;
      logic [7:0] b;
      a = 8'($urandom);
      b = 8'($urandom);
      if (i % 7 == 0) a = 8'h80;
      if (i % 5 == 0) b = 8'h7F;
      start(a, b);
      wait_done();
    end

    repeat (3) @(negedge clk);
    chk("scoreboard_empty", sb.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running want finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/signed_spm.md
# signed_spm

Signed 8×8 serial-parallel multiplier (SPM) producing a 16-bit two's-complement product. Multiplicand X enters in parallel; multiplier Y is shifted through a carry-save cell array bit-serially, LSB first. One product bit is produced per clock. The block is a self-contained arithmetic engine started by a Go pulse and reporting completion on done.

## Interface
Parameters:
- N, default 8: operand width. The product width is 2N; the counter width is clog2(2N)+1.

Ports:
- clk  input  1  rising-edge clock; the only clock.
- R  input  1  reset; asynchronous, active-low.
- X  input  N  signed multiplicand; sampled only on the start edge.
- Y  input  N  signed multiplier; sampled only on the start edge.
- Go  input  1  start request; level-sampled at rising clk.
- done  output  1  result valid; held until the next accepted start.
- P_reg  output  2N  signed product; registered.
- busy  output  1  high while computing; present only with SPM_BUSY_EN.

## Operation
- States:
  - IDLE (reset state).
  - RUN (2N cycles).
  - DONE.
- Start: in IDLE or DONE, Go=1 at a rising edge triggers the following:
  - X and Y are latched.
  - The carry-save sum/carry array is cleared, as are the bit counter and P_reg.
  - done=0 and the state goes to RUN.
- Go in RUN is ignored. X and Y changes after the start edge have no effect.
- RUN: on each edge, multiplier bit y_i is fed, where y_i = Y[i] for i<N and y_i = Y[N-1] for i≥N (sign extension).
  - The array adds y_i·X, with X sign-extended: the MSB cell replicates the sign.
  - The array emits one product bit, LSB first.
  - P_reg shifts right, and the new bit enters P_reg[2N-1].
- After 2N bits, P_reg = (X·Y) mod 2^(2N), interpreted as signed. This is exact for all signed N-bit pairs, including -2^(N-1)·-2^(N-1) = +2^(2N-2).
- DONE: done=1, and P_reg and done hold. A Go in DONE restarts directly.
- Go held high continuously: a new start is accepted each time DONE is reached.

## Timing
- Reset values: P_reg=0, done=0, busy=0, state IDLE, array and counter cleared.
- Reset asserts asynchronously at any time, including mid-RUN. The result is discarded, and no done is produced until a new Go after release.
- Latency: the start edge is edge 0. Product bits are captured on edges 1..2N. On edge 2N, P_reg holds the final product and done rises (same edge). For N=8, done rises 16 cycles after the start edge.
- done deasserts on the next start edge.
- P_reg is a partial value during RUN and is valid only while done=1.
- busy (if enabled) is 1 from the start edge through edge 2N-1 and 0 from edge 2N.

## Configuration
- SPM_BUSY_EN defined:
  - Adds the busy output, registered, asserted exactly in RUN.
- SPM_BUSY_EN undefined:
  - No busy port.
  - Behaviour otherwise identical.

## Structure
- Shared package spm_pkg holds:
  - Default N.
  - Product width 2N.
  - Counter width.
  - State enum {IDLE, RUN, DONE}.
- One sub-module, spm_csa_cell:
  - A full-adder carry-save cell with sum and carry flops.
  - Takes the AND of x_j and y_i, plus the neighbour sum.
  - It is instantiated N times, with the MSB cell configured for sign extension.
- The top level holds the FSM, counter, serial-Y mux and the P_reg shifter.

## Test plan
- Reset R=0 for 2 cycles, then release. Require: P_reg=0 and done=0. Go=0 for 10 cycles → done stays 0.
- X=8'd128 (-128), Y=8'd128 (-128), 1-cycle Go pulse → done rises exactly 16 cycles after the start edge. P_reg=16'h4000 (+16384).
- The following pairs produce the listed products:
  - X=-13 (8'hF3), Y=3 → P_reg=16'hFFD9 (-39).
  - X=127, Y=127 → 16'h3F01.
  - X=-128, Y=127 → 16'hC080.
  - X=0, Y=-1 → 16'h0000.
- Go re-pulsed at cycle 5 of RUN → ignored. The result still completes at cycle 16 with the original operands. X/Y changes mid-RUN do not alter P_reg.
- R asserted at cycle 8 of RUN → P_reg=0 and done=0 immediately (asynchronously). A subsequent Go with X=5, Y=-7 → 16'hFFDD after 16 cycles.
- Back-to-back: Go in DONE with new operands → done drops on the start edge. The new result arrives 16 cycles later. With SPM_BUSY_EN, busy is high for exactly 16 cycles per run.
